// File: rtl/sd_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sd_cmd_arbiter
// Purpose  : Two-requester arbiter in front of a single SD command
//            controller. A granted requester's command fields are latched
//            and issued to the controller. Its data strobes are then routed
//            back until the transfer word count is reached or the controller
//            reports an error. Ties are broken round-robin.
// Ports    : clk, rst_n         - clock, async active-low reset (sync release)
//            reqN_*             - requester N command/data handshake (N=0,1)
//            sd_cmd_*           - latched command to the controller
//            sd_dataIn*         - write-data path to the controller
//            sd_dataOut_valid   - read-word strobe from the controller
//            sd_err             - controller error
//            busy, owner        - transfer in progress, granted requester
// Revision : 1.0 - initial release
// ============================================================================
module sd_cmd_arbiter #(
  parameter int READ_WORDS = 256,
  parameter int LEN_W      = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0
  input  logic             req0_trigger,
  output logic             req0_accepted,
  input  logic             req0_write,
  input  logic [LEN_W-1:0] req0_writeLen,
  input  logic [31:0]      req0_addr,
  input  logic [15:0]      req0_dataIn,
  output logic             req0_dataIn_accepted,
  output logic             req0_dataOut_valid,
  output logic             req0_err,
  // requester 1
  input  logic             req1_trigger,
  output logic             req1_accepted,
  input  logic             req1_write,
  input  logic [LEN_W-1:0] req1_writeLen,
  input  logic [31:0]      req1_addr,
  input  logic [15:0]      req1_dataIn,
  output logic             req1_dataIn_accepted,
  output logic             req1_dataOut_valid,
  output logic             req1_err,
  // controller side
  output logic             sd_cmd_trigger,
  input  logic             sd_cmd_accepted,
  output logic             sd_cmd_write,
  output logic [LEN_W-1:0] sd_cmd_writeLen,
  output logic [31:0]      sd_cmd_addr,
  output logic [15:0]      sd_dataIn,
  input  logic             sd_dataIn_accepted,
  input  logic             sd_dataOut_valid,
  input  logic             sd_err,
  // status
  output logic             busy,
  output logic             owner
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] XFER  = 2'd2;

  // Reset asserts asynchronously but is released two edges after rst_n
  // rises, so no flop sees a reset release close to an active edge.
  logic [1:0] rst_pipe;
  logic       rst_sync_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_sync_n = rst_pipe[1];

  logic [1:0]       state;
  logic             last_grant;
  logic [LEN_W-1:0] cnt;
  logic             lat_write;
  logic [LEN_W-1:0] lat_len;
  logic [31:0]      lat_addr;

  logic             grant_valid;
  logic             grant_idx;
  logic             strobe;
  logic [LEN_W-1:0] target;
  logic [LEN_W-1:0] cnt_inc;
  logic             xfer_done;
  logic             in_issue;
  logic             in_xfer;

  assign in_issue = (state == ISSUE);
  assign in_xfer  = (state == XFER);

  // Round-robin tie break: on a tie the requester not granted last wins.
  always_comb begin
    grant_valid = req0_trigger | req1_trigger;
    if (req0_trigger && req1_trigger) begin
      grant_idx = ~last_grant;
    end else begin
      grant_idx = req1_trigger;
    end
  end

  assign strobe  = lat_write ? sd_dataIn_accepted : sd_dataOut_valid;
  assign target  = lat_write ? lat_len : LEN_W'(READ_WORDS);
  // Saturating increment: the counter never wraps.
  assign cnt_inc = (cnt == {LEN_W{1'b1}}) ? cnt : cnt + LEN_W'(1);
  // A zero-length transfer completes after its single XFER cycle.
  assign xfer_done = (target == '0) || (strobe && (cnt_inc == target));

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      lat_write  <= 1'b0;
      lat_len    <= '0;
      lat_addr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            state      <= ISSUE;
            owner      <= grant_idx;
            last_grant <= grant_idx;
            lat_write  <= grant_idx ? req1_write    : req0_write;
            lat_len    <= grant_idx ? req1_writeLen : req0_writeLen;
            lat_addr   <= grant_idx ? req1_addr     : req0_addr;
          end
        end
        ISSUE: begin
          if (sd_err) begin
            state <= IDLE;
          end else if (sd_cmd_accepted) begin
            state <= XFER;
            cnt   <= '0;
          end
        end
        XFER: begin
          if (sd_err) begin
            state <= IDLE;
          end else begin
            if (strobe) begin
              cnt <= cnt_inc;
            end
            if (xfer_done) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy            = (state != IDLE);
  assign sd_cmd_trigger  = in_issue;
  assign sd_cmd_write    = lat_write;
  assign sd_cmd_writeLen = lat_len;
  assign sd_cmd_addr     = lat_addr;
  assign sd_dataIn       = owner ? req1_dataIn : req0_dataIn;

  // Acceptance is combinational on sd_cmd_accepted so the requester sees
  // it in the same cycle the controller does.
  assign req0_accepted = in_issue && !owner && sd_cmd_accepted;
  assign req1_accepted = in_issue &&  owner && sd_cmd_accepted;

  assign req0_dataIn_accepted = in_xfer && !owner && sd_dataIn_accepted;
  assign req1_dataIn_accepted = in_xfer &&  owner && sd_dataIn_accepted;
  assign req0_dataOut_valid   = in_xfer && !owner && sd_dataOut_valid;
  assign req1_dataOut_valid   = in_xfer &&  owner && sd_dataOut_valid;

  // The error pulse lasts one cycle because the same edge returns to IDLE.
  assign req0_err = busy && !owner && sd_err;
  assign req1_err = busy &&  owner && sd_err;

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_cmd_arbiter
// Purpose  : Self-checking bench for sd_cmd_arbiter. The bench acts as both
//            requesters and the controller; a transaction-level model
//            (pending requests, last winner, expected word counts) predicts
//            grants and per-requester strobe totals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_cmd_arbiter;

  localparam int RW = 256;
  localparam int LW = 23;

  logic          clk;
  logic          rst_n;
  logic          req0_trigger, req1_trigger;
  logic          req0_accepted, req1_accepted;
  logic          req0_write, req1_write;
  logic [LW-1:0] req0_writeLen, req1_writeLen;
  logic [31:0]   req0_addr, req1_addr;
  logic [15:0]   req0_dataIn, req1_dataIn;
  logic          req0_dataIn_accepted, req1_dataIn_accepted;
  logic          req0_dataOut_valid, req1_dataOut_valid;
  logic          req0_err, req1_err;
  logic          sd_cmd_trigger, sd_cmd_accepted, sd_cmd_write;
  logic [LW-1:0] sd_cmd_writeLen;
  logic [31:0]   sd_cmd_addr;
  logic [15:0]   sd_dataIn;
  logic          sd_dataIn_accepted, sd_dataOut_valid, sd_err;
  logic          busy, owner;

  sd_cmd_arbiter #(.READ_WORDS(RW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_trigger(req0_trigger), .req0_accepted(req0_accepted),
    .req0_write(req0_write), .req0_writeLen(req0_writeLen),
    .req0_addr(req0_addr), .req0_dataIn(req0_dataIn),
    .req0_dataIn_accepted(req0_dataIn_accepted),
    .req0_dataOut_valid(req0_dataOut_valid), .req0_err(req0_err),
    .req1_trigger(req1_trigger), .req1_accepted(req1_accepted),
    .req1_write(req1_write), .req1_writeLen(req1_writeLen),
    .req1_addr(req1_addr), .req1_dataIn(req1_dataIn),
    .req1_dataIn_accepted(req1_dataIn_accepted),
    .req1_dataOut_valid(req1_dataOut_valid), .req1_err(req1_err),
    .sd_cmd_trigger(sd_cmd_trigger), .sd_cmd_accepted(sd_cmd_accepted),
    .sd_cmd_write(sd_cmd_write), .sd_cmd_writeLen(sd_cmd_writeLen),
    .sd_cmd_addr(sd_cmd_addr), .sd_dataIn(sd_dataIn),
    .sd_dataIn_accepted(sd_dataIn_accepted),
    .sd_dataOut_valid(sd_dataOut_valid), .sd_err(sd_err),
    .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit m_last;  // model: requester granted most recently

  // Pulse totals per requester, sampled mid-cycle.
  int n_acc[2], n_val[2], n_din[2], n_err[2];
  int b_acc[2], b_val[2], b_din[2], b_err[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      n_acc[i] = 0; n_val[i] = 0; n_din[i] = 0; n_err[i] = 0;
    end
  end

  always @(negedge clk) begin
    if (req0_accepted)        n_acc[0]++;
    if (req1_accepted)        n_acc[1]++;
    if (req0_dataOut_valid)   n_val[0]++;
    if (req1_dataOut_valid)   n_val[1]++;
    if (req0_dataIn_accepted) n_din[0]++;
    if (req1_dataIn_accepted) n_din[1]++;
    if (req0_err)             n_err[0]++;
    if (req1_err)             n_err[1]++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      b_acc[i] = n_acc[i]; b_val[i] = n_val[i];
      b_din[i] = n_din[i]; b_err[i] = n_err[i];
    end
  endtask

  // Controller emulation: wait for the command, accept after lat cycles,
  // drop the accepted requester's trigger, then deliver nwords strobes.
  task automatic serve(input int lat, input int nwords, input bit is_write,
                       output bit to);
    int guard;
    bit d0, d1;
    to = 1'b0;
    guard = 0;
    while (sd_cmd_trigger !== 1'b1 && guard < 50) begin
      cyc();
      guard++;
    end
    if (sd_cmd_trigger !== 1'b1) begin
      to = 1'b1;
      return;
    end
    repeat (lat) cyc();
    sd_cmd_accepted = 1'b1;
    @(negedge clk);
    d0 = req0_accepted;
    d1 = req1_accepted;
    cyc();
    sd_cmd_accepted = 1'b0;
    if (d0) req0_trigger = 1'b0;
    if (d1) req1_trigger = 1'b0;
    for (int w = 0; w < nwords; w++) begin
      repeat ($urandom_range(0, 1)) cyc();
      if (is_write) sd_dataIn_accepted = 1'b1;
      else          sd_dataOut_valid   = 1'b1;
      cyc();
      sd_dataIn_accepted = 1'b0;
      sd_dataOut_valid   = 1'b0;
    end
    if (nwords == 0) cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_trigger = 1'b1; req1_trigger = 1'b1;
    sd_cmd_accepted = 1'b1; sd_err = 1'b1; sd_dataOut_valid = 1'b1;
    sd_dataIn_accepted = 1'b1;
    repeat (2) cyc();
    @(negedge clk);
    checks++;
    if ({req0_accepted, req1_accepted, req0_err, req1_err, sd_cmd_trigger,
         req0_dataOut_valid, req1_dataIn_accepted} !== 7'b0) begin
      errors++;
      $display("FAIL reset_pulses got %b want 0000000",
               {req0_accepted, req1_accepted, req0_err, req1_err, sd_cmd_trigger,
                req0_dataOut_valid, req1_dataIn_accepted});
    end
    cyc();
    req0_trigger = 1'b0; req1_trigger = 1'b0;
    sd_cmd_accepted = 1'b0; sd_err = 1'b0; sd_dataOut_valid = 1'b0;
    sd_dataIn_accepted = 1'b0;
    rst_n = 1'b1;
    repeat (3) cyc();
    m_last = 1'b1;
    checks++;
    if (busy !== 1'b0 || owner !== 1'b0) begin
      errors++;
      $display("FAIL reset_state busy/owner got %b%b want 00", busy, owner);
    end
    checks++;
    if (sd_cmd_addr !== 32'h0 || sd_cmd_writeLen !== '0 || sd_cmd_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_fields got addr %h len %0d wr %b want 0 0 0",
               sd_cmd_addr, sd_cmd_writeLen, sd_cmd_write);
    end
  endtask

  task automatic test_tie();
    bit e, to;
    logic [31:0] a[2];
    a[0] = 32'h100; a[1] = 32'h200;
    req0_write = 1'b1; req1_write = 1'b1;
    req0_writeLen = 2; req1_writeLen = 2;
    req0_addr = a[0]; req1_addr = a[1];
    req0_trigger = 1'b1; req1_trigger = 1'b1;
    for (int r = 0; r < 3; r++) begin
      e = (req0_trigger && req1_trigger) ? ~m_last : req1_trigger;
      cyc();
      checks++;
      if (sd_cmd_trigger !== 1'b1 || owner !== e || sd_cmd_addr !== a[e]) begin
        errors++;
        $display("FAIL tie_grant%0d got trig %b owner %b addr %h want 1 %b %h",
                 r, sd_cmd_trigger, owner, sd_cmd_addr, e, a[e]);
      end
      snap();
      serve(1, 2, 1'b1, to);
      checks++;
      if (to || busy !== 1'b0 || n_acc[e] - b_acc[e] != 1 || n_din[e] - b_din[e] != 2) begin
        errors++;
        $display("FAIL tie_xfer%0d got to %b busy %b acc %0d din %0d want 0 0 1 2", r,
                 to, busy, n_acc[e] - b_acc[e], n_din[e] - b_din[e]);
      end
      m_last = e;
      if (r == 0) begin
        if (e) req1_trigger = 1'b1;
        else   req0_trigger = 1'b1;
      end
    end
  endtask

  task automatic test_single_read();
    snap();
    req0_write = 1'b0; req0_addr = 32'h10; req0_trigger = 1'b1;
    cyc();
    checks++;
    if (sd_cmd_trigger !== 1'b1 || owner !== 1'b0 || sd_cmd_addr !== 32'h10 || sd_cmd_write !== 1'b0) begin
      errors++;
      $display("FAIL read_grant got trig %b owner %b addr %h wr %b want 1 0 00000010 0",
               sd_cmd_trigger, owner, sd_cmd_addr, sd_cmd_write);
    end
    // Owner inputs move after grant; a stray strobe arrives during ISSUE.
    req0_addr = 32'hDEAD_BEEF; req0_write = 1'b1;
    sd_dataOut_valid = 1'b1;
    cyc();
    sd_dataOut_valid = 1'b0;
    repeat (2) cyc();
    checks++;
    if (sd_cmd_addr !== 32'h10 || sd_cmd_write !== 1'b0 || n_acc[0] != b_acc[0]) begin
      errors++;
      $display("FAIL read_latched got addr %h wr %b acc %0d want 00000010 0 0",
               sd_cmd_addr, sd_cmd_write, n_acc[0] - b_acc[0]);
    end
    sd_cmd_accepted = 1'b1;
    cyc();
    sd_cmd_accepted = 1'b0;
    req0_trigger = 1'b0;
    for (int w = 0; w < RW; w++) begin
      repeat ($urandom_range(0, 1)) cyc();
      if (w == RW - 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL read_busy_before_last got %b want 1", busy);
        end
      end
      sd_dataOut_valid = 1'b1;
      cyc();
      sd_dataOut_valid = 1'b0;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL read_busy_after_last got %b want 0", busy);
    end
    // A strobe in IDLE is not forwarded.
    sd_dataOut_valid = 1'b1;
    cyc();
    sd_dataOut_valid = 1'b0;
    checks++;
    if (n_acc[0] - b_acc[0] != 1 || n_val[0] - b_val[0] != RW || n_val[1] != b_val[1]) begin
      errors++;
      $display("FAIL read_counts got acc0 %0d val0 %0d val1 %0d want 1 %0d 0",
               n_acc[0] - b_acc[0], n_val[0] - b_val[0], n_val[1] - b_val[1], RW);
    end
    m_last = 1'b0;
  endtask

  task automatic test_write();
    int strobes, guard;
    snap();
    req1_write = 1'b1; req1_writeLen = 4; req1_addr = 32'h55; req1_trigger = 1'b1;
    cyc();
    checks++;
    if (owner !== 1'b1 || sd_cmd_write !== 1'b1 || sd_cmd_writeLen !== 4 || sd_cmd_addr !== 32'h55) begin
      errors++;
      $display("FAIL write_grant got owner %b wr %b len %0d addr %h want 1 1 4 00000055",
               owner, sd_cmd_write, sd_cmd_writeLen, sd_cmd_addr);
    end
    repeat (2) cyc();
    sd_cmd_accepted = 1'b1;
    cyc();
    sd_cmd_accepted = 1'b0;
    req1_trigger = 1'b0;
    strobes = 0;
    guard = 0;
    while (strobes < 4 && guard < 40) begin
      req0_dataIn = 16'($urandom);
      req1_dataIn = 16'($urandom);
      sd_dataIn_accepted = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (sd_dataIn !== req1_dataIn) begin
        errors++;
        $display("FAIL write_dataIn got %h want %h", sd_dataIn, req1_dataIn);
      end
      if (sd_dataIn_accepted) strobes++;
      cyc();
      guard++;
    end
    sd_dataIn_accepted = 1'b0;
    checks++;
    if (busy !== 1'b0 || n_din[1] - b_din[1] != 4 || n_din[0] != b_din[0] ||
        n_val[0] != b_val[0] || n_val[1] != b_val[1]) begin
      errors++;
      $display("FAIL write_counts got busy %b din1 %0d din0 %0d val %0d/%0d want 0 4 0 0/0",
               busy, n_din[1] - b_din[1], n_din[0] - b_din[0],
               n_val[0] - b_val[0], n_val[1] - b_val[1]);
    end
    m_last = 1'b1;
  endtask

  task automatic test_error();
    bit to;
    // sd_err while idle is ignored.
    sd_err = 1'b1;
    @(negedge clk);
    checks++;
    if (req0_err !== 1'b0 || req1_err !== 1'b0) begin
      errors++;
      $display("FAIL err_idle got %b%b want 00", req0_err, req1_err);
    end
    cyc();
    sd_err = 1'b0;
    snap();
    req0_write = 1'b0; req0_addr = 32'h20; req0_trigger = 1'b1;
    cyc();
    req1_write = 1'b1; req1_writeLen = 1; req1_addr = 32'h77; req1_trigger = 1'b1;
    sd_cmd_accepted = 1'b1;
    cyc();
    sd_cmd_accepted = 1'b0;
    req0_trigger = 1'b0;
    repeat (10) begin
      sd_dataOut_valid = 1'b1;
      cyc();
      sd_dataOut_valid = 1'b0;
    end
    sd_err = 1'b1;
    @(negedge clk);
    checks++;
    if (req0_err !== 1'b1 || req1_err !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse got %b%b want 10", req0_err, req1_err);
    end
    cyc();
    sd_err = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL err_idle_next got busy %b want 0", busy);
    end
    cyc();
    checks++;
    if (sd_cmd_trigger !== 1'b1 || owner !== 1'b1 || sd_cmd_addr !== 32'h77) begin
      errors++;
      $display("FAIL err_next_grant got trig %b owner %b addr %h want 1 1 00000077",
               sd_cmd_trigger, owner, sd_cmd_addr);
    end
    serve(0, 1, 1'b1, to);
    checks++;
    if (to || busy !== 1'b0 || n_err[0] - b_err[0] != 1 || n_err[1] != b_err[1] ||
        n_val[0] - b_val[0] != 10 || n_din[1] - b_din[1] != 1) begin
      errors++;
      $display("FAIL err_counts got to %b busy %b err0 %0d err1 %0d val0 %0d din1 %0d want 0 0 1 0 10 1",
               to, busy, n_err[0] - b_err[0], n_err[1] - b_err[1],
               n_val[0] - b_val[0], n_din[1] - b_din[1]);
    end
    m_last = 1'b1;
  endtask

  task automatic test_zero_len();
    snap();
    req0_write = 1'b1; req0_writeLen = 0; req0_addr = 32'h99; req0_trigger = 1'b1;
    cyc();
    sd_cmd_accepted = 1'b1;
    cyc();
    sd_cmd_accepted = 1'b0;
    req0_trigger = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_xfer_cycle got busy %b want 1", busy);
    end
    cyc();
    checks++;
    if (busy !== 1'b0 || n_din[0] != b_din[0] || n_acc[0] - b_acc[0] != 1) begin
      errors++;
      $display("FAIL zero_done got busy %b din0 %0d acc0 %0d want 0 0 1",
               busy, n_din[0] - b_din[0], n_acc[0] - b_acc[0]);
    end
    m_last = 1'b0;
  endtask

  task automatic test_random();
    bit pend[2], nw[2], mwr[2], e, to;
    int mlen[2], words;
    logic [31:0] maddr[2];
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 2; i++) nw[i] = !pend[i] && ($urandom_range(0, 1) == 1);
      if (!pend[0] && !pend[1] && !nw[0] && !nw[1]) nw[0] = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (nw[i]) begin
          pend[i]  = 1'b1;
          mwr[i]   = ($urandom_range(0, 3) != 0);
          mlen[i]  = $urandom_range(0, 5);
          maddr[i] = $urandom;
          if (i == 0) begin
            req0_write = mwr[0]; req0_writeLen = LW'(mlen[0]);
            req0_addr = maddr[0]; req0_trigger = 1'b1;
          end else begin
            req1_write = mwr[1]; req1_writeLen = LW'(mlen[1]);
            req1_addr = maddr[1]; req1_trigger = 1'b1;
          end
        end
      end
      e = (pend[0] && pend[1]) ? ~m_last : pend[1];
      words = mwr[e] ? mlen[e] : RW;
      cyc();
      checks++;
      if (sd_cmd_trigger !== 1'b1 || owner !== e || sd_cmd_addr !== maddr[e] ||
          sd_cmd_write !== mwr[e] || sd_cmd_writeLen !== LW'(mlen[e])) begin
        errors++;
        $display("FAIL rand_grant%0d got owner %b addr %h wr %b len %0d want %b %h %b %0d",
                 r, owner, sd_cmd_addr, sd_cmd_write, sd_cmd_writeLen,
                 e, maddr[e], mwr[e], mlen[e]);
      end
      snap();
      serve($urandom_range(0, 3), words, mwr[e], to);
      checks++;
      if (to || busy !== 1'b0 || n_acc[e] - b_acc[e] != 1 || n_acc[!e] != b_acc[!e] ||
          (mwr[e] ? n_din[e] - b_din[e] : n_val[e] - b_val[e]) != words ||
          n_din[!e] != b_din[!e] || n_val[!e] != b_val[!e]) begin
        errors++;
        $display("FAIL rand_xfer%0d got to %b busy %b acc %0d/%0d din %0d/%0d val %0d/%0d want owner %b words %0d",
                 r, to, busy, n_acc[0] - b_acc[0], n_acc[1] - b_acc[1],
                 n_din[0] - b_din[0], n_din[1] - b_din[1],
                 n_val[0] - b_val[0], n_val[1] - b_val[1], e, words);
      end
      pend[e] = 1'b0;
      m_last = e;
    end
  endtask

  task automatic test_reset_mid();
    snap();
    req1_write = 1'b0; req1_addr = 32'h33; req1_trigger = 1'b1;
    cyc();
    sd_cmd_accepted = 1'b1;
    cyc();
    sd_cmd_accepted = 1'b0;
    req1_trigger = 1'b0;
    repeat (3) begin
      sd_dataOut_valid = 1'b1;
      cyc();
      sd_dataOut_valid = 1'b0;
    end
    rst_n = 1'b0;
    sd_err = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || sd_cmd_trigger !== 1'b0 || owner !== 1'b0 || req1_err !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async got busy %b trig %b owner %b err1 %b want 0 0 0 0",
               busy, sd_cmd_trigger, owner, req1_err);
    end
    repeat (2) cyc();
    sd_err = 1'b0;
    rst_n = 1'b1;
    repeat (3) cyc();
    m_last = 1'b1;
    checks++;
    if (n_err[0] != b_err[0] || n_err[1] != b_err[1] || n_val[1] - b_val[1] != 3) begin
      errors++;
      $display("FAIL rstmid_counts got err %0d/%0d val1 %0d want 0/0 3",
               n_err[0] - b_err[0], n_err[1] - b_err[1], n_val[1] - b_val[1]);
    end
    // Tie history is cleared: requester 0 wins the first tie again.
    req0_trigger = 1'b1; req1_trigger = 1'b1;
    cyc();
    checks++;
    if (owner !== ~m_last || sd_cmd_trigger !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_tie got owner %b trig %b want %b 1", owner, sd_cmd_trigger, ~m_last);
    end
    req0_trigger = 1'b0; req1_trigger = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_trigger = 1'b0; req1_trigger = 1'b0;
    req0_write = 1'b0; req1_write = 1'b0;
    req0_writeLen = '0; req1_writeLen = '0;
    req0_addr = '0; req1_addr = '0;
    req0_dataIn = '0; req1_dataIn = '0;
    sd_cmd_accepted = 1'b0; sd_dataIn_accepted = 1'b0;
    sd_dataOut_valid = 1'b0; sd_err = 1'b0;
    m_last = 1'b1;
    #1;
    test_reset();
    test_tie();
    test_single_read();
    test_write();
    test_error();
    test_zero_len();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sd_cmd_arbiter.md
SD_CMD_ARBITER -- requirements
Module: sd_cmd_arbiter

Interface
REQ-001 SHALL have parameter READ_WORDS, default 256, meaning the number of 16-bit dataOut words in one read transfer (one 512-byte block).
REQ-002 SHALL have parameter LEN_W, default 23, meaning the width of the writeLen field.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req0_trigger / req1_trigger  in  1  command request from requester N; held high until reqN_accepted.
REQ-006 SHALL have ports req0_accepted / req1_accepted  out  1  one-cycle acceptance pulse to requester N.
REQ-007 SHALL have ports req0_write / req1_write  in  1  1 = write transfer, 0 = read transfer.
REQ-008 SHALL have ports req0_writeLen / req1_writeLen  in  LEN_W  write length in 16-bit words.
REQ-009 SHALL have ports req0_addr / req1_addr  in  32  SD block address.
REQ-010 SHALL have ports req0_dataIn / req1_dataIn  in  16  write data from requester N.
REQ-011 SHALL have ports req0_dataIn_accepted / req1_dataIn_accepted  out  1  write word consumed from requester N.
REQ-012 SHALL have ports req0_dataOut_valid / req1_dataOut_valid  out  1  read word valid for requester N; data is on the shared sd_dataOut.
REQ-013 SHALL have ports req0_err / req1_err  out  1  one-cycle abort pulse to requester N.
REQ-014 SHALL have port sd_cmd_trigger  out  1  command request to the controller.
REQ-015 SHALL have port sd_cmd_accepted  in  1  controller accepted the command.
REQ-016 SHALL have ports sd_cmd_write (out, 1), sd_cmd_writeLen (out, LEN_W) and sd_cmd_addr (out, 32)  latched command fields.
REQ-017 SHALL have ports sd_dataIn (out, 16) and sd_dataIn_accepted (in, 1)  write-data path to the controller.
REQ-018 SHALL have port sd_dataOut_valid  in  1  controller read-word strobe.
REQ-019 SHALL have port sd_err  in  1  controller error.
REQ-020 SHALL have ports busy (out, 1) and owner (out, 1)  transfer in progress; index of the granted requester.

Function
REQ-021 SHALL implement FSM states IDLE, ISSUE and XFER.
REQ-022 In IDLE with exactly one reqN_trigger high, SHALL grant N, latch its write/writeLen/addr, and enter ISSUE on the next edge.
REQ-023 In IDLE with both triggers high, SHALL grant the requester not granted last; after reset, requester 0 wins the first tie.
REQ-024 SHALL assert sd_cmd_trigger combinationally as (state==ISSUE); changes to owner inputs after grant SHALL have no effect on the latched fields.
REQ-025 SHALL drive reqN_accepted = (state==ISSUE) && owner==N && sd_cmd_accepted, so acceptance is zero-latency relative to the controller; ISSUE -> XFER on that same edge, with the word counter cleared.
REQ-026 In XFER, SHALL increment the counter on sd_dataIn_accepted for writes and on sd_dataOut_valid for reads.
REQ-027 In XFER, SHALL return to IDLE on the edge where the count reaches its target (writeLen for writes, READ_WORDS for reads).
REQ-028 A write with writeLen==0 SHALL go ISSUE -> XFER -> IDLE with no data cycles, leaving XFER after exactly one cycle.
REQ-029 sd_dataIn SHALL equal reqOwner_dataIn; reqN_dataIn_accepted and reqN_dataOut_valid SHALL pass through only for N==owner and state==XFER; the non-owner always sees 0.
REQ-030 On sd_err high in ISSUE or XFER, SHALL pulse req<owner>_err for one cycle and enter IDLE; sd_err in IDLE SHALL be ignored.
REQ-031 The counter SHALL be LEN_W bits wide, never wrap, and ignore strobes arriving in IDLE or ISSUE.
REQ-032 busy SHALL be (state!=IDLE).
REQ-033 owner SHALL hold its value in IDLE and update only on grant.
REQ-034 A trigger from the non-owner during ISSUE/XFER SHALL wait without acceptance and be arbitrated in the next IDLE cycle.

Reset
REQ-035 On rst_n low, SHALL asynchronously force state=IDLE, owner=0, last-granted=1 (so requester 0 wins the first tie), counter=0, and latched fields=0.
REQ-036 While rst_n is low, all pulse outputs and sd_cmd_trigger SHALL be 0.
REQ-037 Reset mid-transfer SHALL abandon the transfer with no err pulse.
REQ-038 Release of rst_n SHALL be synchronised to clk so the first active edge is clean.

Verification
REQ-039 Single read: req0 read addr=0x10, controller accepts after 3 cycles and sends 256 strobes -> one req0_accepted pulse, 256 req0_dataOut_valid pulses, busy drops on the edge after the 256th strobe.
REQ-040 Tie: both trigger in the same cycle twice in succession -> grants req0 then req1; sd_cmd_addr matches each owner.
REQ-041 Write: req1 write writeLen=4 -> exactly 4 req1_dataIn_accepted pulses; sd_dataIn tracks req1_dataIn; req0 sees no strobes.
REQ-042 Error: sd_err at word 10 of a req0 read -> one req0_err pulse, state IDLE next cycle, waiting req1 granted immediately after.
REQ-043 Zero length and reset: a writeLen=0 write completes with no data cycles; rst_n low during XFER -> busy=0 asynchronously and no err pulse.
